// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb
//  Description : Two-port arbiter/sequencer in front of the byte-wide async
//                SRAM controller. Shares it between a 32-bit CPU port (A,
//                word access with byte selects) and an 8-bit DMA port (B).
//                Each grant is split into byte cycles on the go/busy
//                handshake; one ack pulse is returned per access.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arb (
    input  logic        clk,
    input  logic        rst,
    // CPU port (A)
    input  logic        a_req,
    input  logic        a_we,
    input  logic [14:0] a_adr,
    input  logic [3:0]  a_sel,
    input  logic [31:0] a_wdat,
    output logic [31:0] a_rdat,
    output logic        a_ack,
    // DMA port (B)
    input  logic        b_req,
    input  logic        b_we,
    input  logic [16:0] b_adr,
    input  logic [7:0]  b_wdat,
    output logic [7:0]  b_rdat,
    output logic        b_ack,
    // SRAM controller side
    output logic        m_go,
    output logic        m_wr,
    output logic [16:0] m_adr,
    output logic [7:0]  m_dat,
    input  logic        m_busy,
    input  logic [7:0]  m_rdt
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;
    localparam logic [1:0] C_ACK   = 2'd3;

    // {valid, lane} of the lowest selected lane
    function automatic logic [2:0] f_first(input logic [3:0] sel);
        f_first = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) f_first = {1'b1, i[1:0]};
        end
    endfunction

    // {valid, lane} of the lowest selected lane strictly above 'lane'
    function automatic logic [2:0] f_next(input logic [3:0] sel, input logic [1:0] lane);
        f_next = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i] && (i > int'(lane))) f_next = {1'b1, i[1:0]};
        end
    endfunction

    function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] lane);
        f_byte = d[{lane, 3'b000} +: 8];
    endfunction

    logic [1:0]  r_state;
    logic        r_last;     // port granted on the last tie: 1 = B
    logic        r_port;     // port currently granted: 1 = B
    logic        r_we;
    logic [14:0] r_wadr;
    logic [31:0] r_wdat;
    logic [3:0]  r_sel;
    logic [1:0]  r_lane;
    logic [31:0] r_rbuf;
    logic        r_go;
    logic        r_wr;
    logic [16:0] r_madr;
    logic [7:0]  r_mdat;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [31:0] r_a_rdat;
    logic [7:0]  r_b_rdat;

    logic        w_any;
    logic        w_tie;
    logic        w_pick_b;
    logic        w_in_we;
    logic [31:0] w_in_wdat;
    logic [3:0]  w_in_sel;
    logic [2:0]  w_first;
    logic [16:0] w_in_madr;
    logic [2:0]  w_next;
    logic [31:0] w_merged;

    // Grant selection and the byte-lane bookkeeping for the active access
    always_comb begin
        w_any     = a_req | b_req;
        w_tie     = a_req & b_req;
        w_pick_b  = b_req & (~a_req | ~r_last);
        w_in_we   = w_pick_b ? b_we : a_we;
        w_in_wdat = w_pick_b ? {24'h00_0000, b_wdat} : a_wdat;
        w_in_sel  = w_pick_b ? 4'b0001 : a_sel;
        w_first   = f_first(w_in_sel);
        w_in_madr = w_pick_b ? b_adr : {a_adr, w_first[1:0]};
        w_next    = f_next(r_sel, r_lane);
        w_merged  = r_rbuf;
        w_merged[{r_lane, 3'b000} +: 8] = m_rdt;
    end

    // Arbitration / byte sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= C_IDLE;
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_wadr   <= '0;
            r_wdat   <= '0;
            r_sel    <= '0;
            r_lane   <= '0;
            r_rbuf   <= '0;
            r_go     <= 1'b0;
            r_wr     <= 1'b0;
            r_madr   <= '0;
            r_mdat   <= '0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_rdat <= '0;
            r_b_rdat <= '0;
        end else begin
            r_go    <= 1'b0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    // The controller may still be finishing a cycle cut short by reset
                    if (!m_busy && w_any) begin
                        r_port <= w_pick_b;
                        if (w_tie) r_last <= w_pick_b;
                        r_we   <= w_in_we;
                        r_wadr <= a_adr;
                        r_wdat <= w_in_wdat;
                        r_sel  <= w_in_sel;
                        r_rbuf <= '0;
                        if (w_first[2]) begin
                            r_lane  <= w_first[1:0];
                            r_go    <= 1'b1;
                            r_wr    <= w_in_we;
                            r_madr  <= w_in_madr;
                            r_mdat  <= f_byte(w_in_wdat, w_first[1:0]);
                            r_state <= C_ISSUE;
                        end else begin
                            // No lanes selected (A only): complete without an SRAM cycle
                            r_a_ack <= 1'b1;
                            if (!a_we) r_a_rdat <= '0;
                            r_state <= C_ACK;
                        end
                    end
                end
                C_ISSUE: begin
                    r_state <= C_WAIT;
                end
                C_WAIT: begin
                    if (!m_busy) begin
                        if (!r_we) begin
                            if (r_port) r_b_rdat <= m_rdt;
                            else        r_rbuf   <= w_merged;
                        end
                        if (w_next[2]) begin
                            // Only port A can have further lanes
                            r_lane  <= w_next[1:0];
                            r_go    <= 1'b1;
                            r_madr  <= {r_wadr, w_next[1:0]};
                            r_mdat  <= f_byte(r_wdat, w_next[1:0]);
                            r_state <= C_ISSUE;
                        end else begin
                            if (r_port) begin
                                r_b_ack <= 1'b1;
                            end else begin
                                r_a_ack <= 1'b1;
                                if (!r_we) r_a_rdat <= w_merged;
                            end
                            r_state <= C_ACK;
                        end
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign a_rdat = r_a_rdat;
    assign a_ack  = r_a_ack;
    assign b_rdat = r_b_rdat;
    assign b_ack  = r_b_ack;
    assign m_go   = r_go;
    assign m_wr   = r_wr;
    assign m_adr  = r_madr;
    assign m_dat  = r_mdat;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arb
//  Description : Scoreboard bench for sram_arb with a behavioural model of
//                the byte-wide SRAM controller (busy for 6 cycles per go).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [14:0] a_adr = '0;
    logic [3:0]  a_sel = '0;
    logic [31:0] a_wdat = '0;
    logic [31:0] a_rdat;
    logic        a_ack;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [16:0] b_adr = '0;
    logic [7:0]  b_wdat = '0;
    logic [7:0]  b_rdat;
    logic        b_ack;
    logic        m_go, m_wr;
    logic [16:0] m_adr;
    logic [7:0]  m_dat;
    logic        m_busy = 1'b0;
    logic [7:0]  m_rdt = '0;

    always #10 clk = ~clk;

    sram_arb dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_sel(a_sel), .a_wdat(a_wdat),
        .a_rdat(a_rdat), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat),
        .b_rdat(b_rdat), .b_ack(b_ack),
        .m_go(m_go), .m_wr(m_wr), .m_adr(m_adr), .m_dat(m_dat),
        .m_busy(m_busy), .m_rdt(m_rdt)
    );

    // SRAM controller model: no reset, busy in the 6 cycles after go
    logic [7:0] mem [0:131071];
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (m_go) begin
            m_busy   <= 1'b1;
            busy_cnt <= 5;
            if (m_wr) mem[m_adr] <= m_dat;
            m_rdt <= mem[m_adr];
        end else if (m_busy) begin
            if (busy_cnt == 0) m_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { bit rd; logic [31:0] rdat; int cyc; } exp_t;
    typedef struct { logic [16:0] adr; logic [7:0] dat; bit wr; } go_t;
    exp_t exp_a[$];
    exp_t exp_b[$];
    go_t  go_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s", msg);
    endtask

    // Monitor: pops expectations whenever the DUT presents an ack or a go
    bit          prev_go = 1'b0;
    bit          stab_ok = 1'b0;
    logic [16:0] lat_adr;
    logic [7:0]  lat_dat;
    logic        lat_wr;
    exp_t        me;
    go_t         mg;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            prev_go = 1'b0;
            stab_ok = 1'b0;
        end else begin
            if (a_ack && b_ack) flag("acks_coincide: a_ack and b_ack both high");
            if (a_ack) begin
                if (exp_a.size() == 0) flag("a_ack_unexpected: got ack, required none");
                else begin
                    me = exp_a.pop_front();
                    if (me.cyc >= 0) chk("a_ack_cycle", cyc, me.cyc);
                    if (me.rd) chk("a_rdat", a_rdat, me.rdat);
                end
            end
            if (b_ack) begin
                if (exp_b.size() == 0) flag("b_ack_unexpected: got ack, required none");
                else begin
                    me = exp_b.pop_front();
                    if (me.cyc >= 0) chk("b_ack_cycle", cyc, me.cyc);
                    if (me.rd) chk("b_rdat", b_rdat, me.rdat[7:0]);
                end
            end
            if (m_busy && stab_ok && ({m_wr, m_adr, m_dat} !== {lat_wr, lat_adr, lat_dat}))
                flag($sformatf("bus_stable: got %0h/%0h/%0h, required %0h/%0h/%0h",
                               m_wr, m_adr, m_dat, lat_wr, lat_adr, lat_dat));
            if (m_go) begin
                chk("go_while_busy", m_busy, 0);
                if (prev_go) flag("go_pulse: got 2 cycles, required 1");
                if (go_q.size() == 0) flag($sformatf("go_unexpected: got adr %0h, required none", m_adr));
                else begin
                    mg = go_q.pop_front();
                    chk("go_adr", m_adr, mg.adr);
                    chk("go_wr", m_wr, mg.wr);
                    if (mg.wr) chk("go_dat", m_dat, mg.dat);
                end
                lat_adr = m_adr;
                lat_dat = m_dat;
                lat_wr  = m_wr;
                stab_ok = 1'b1;
            end
            prev_go = m_go;
        end
    end

    task automatic push_go(input logic [16:0] adr, input logic [7:0] dat, input bit wr);
        go_t g;
        g.adr = adr; g.dat = dat; g.wr = wr;
        go_q.push_back(g);
    endtask

    task automatic push_exp(input bit port_b, input bit rd, input logic [31:0] rdat, input int c);
        exp_t e;
        e.rd = rd; e.rdat = rdat; e.cyc = c;
        if (port_b) exp_b.push_back(e);
        else        exp_a.push_back(e);
    endtask

    task automatic wait_ack_a();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_ack) begin ok = 1'b1; break; end
        end
        if (!ok) flag("a_ack_timeout: got no ack, required ack");
    endtask

    task automatic wait_ack_b();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_ack) begin ok = 1'b1; break; end
        end
        if (!ok) flag("b_ack_timeout: got no ack, required ack");
    endtask

    task automatic run_a(input bit we, input logic [14:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, input logic [31:0] rdat, input int lat);
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_adr = adr; a_sel = sel; a_wdat = wdat;
        push_exp(1'b0, !we, rdat, cyc + 1 + lat);
        wait_ack_a();
        a_req = 1'b0;
    endtask

    task automatic run_b(input bit we, input logic [16:0] adr, input logic [7:0] wdat,
                         input logic [7:0] rdat, input int lat);
        @(negedge clk);
        b_req = 1'b1; b_we = we; b_adr = adr; b_wdat = wdat;
        push_exp(1'b1, !we, {24'h0, rdat}, cyc + 1 + lat);
        wait_ack_b();
        b_req = 1'b0;
    endtask

    int n_go;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_a", {a_rdat, a_ack}, 64'h0);
        chk("reset_b_m", {b_rdat, b_ack, m_go, m_wr, m_adr, m_dat}, 64'h0);
        rst = 1'b0;

        // B single byte write, then read back
        push_go(17'h1_0005, 8'hA5, 1'b1);
        run_b(1'b1, 17'h1_0005, 8'hA5, 8'h00, 8);
        push_go(17'h1_0005, 8'h00, 1'b0);
        run_b(1'b0, 17'h1_0005, 8'h00, 8'hA5, 8);

        // A full word write and read back
        push_go(17'h0_0040, 8'h78, 1'b1);
        push_go(17'h0_0041, 8'h56, 1'b1);
        push_go(17'h0_0042, 8'h34, 1'b1);
        push_go(17'h0_0043, 8'h12, 1'b1);
        run_a(1'b1, 15'h0010, 4'hF, 32'h1234_5678, 32'h0, 32);
        for (int i = 0; i < 4; i++) push_go(17'(17'h40 + i), 8'h00, 1'b0);
        run_a(1'b0, 15'h0010, 4'hF, 32'h0, 32'h1234_5678, 32);

        // Sparse selects: lanes 1 and 3 only, others read as zero
        push_go(17'h0_0041, 8'h00, 1'b0);
        push_go(17'h0_0043, 8'h00, 1'b0);
        run_a(1'b0, 15'h0010, 4'b1010, 32'h0, 32'h1200_5600, 16);

        // No lanes selected: ack in cycle 0, no SRAM cycle, read registers untouched
        run_a(1'b1, 15'h0011, 4'h0, 32'hFFFF_FFFF, 32'h0, 0);
        chk("a_rdat_hold", a_rdat, 32'h1200_5600);
        chk("b_rdat_hold", b_rdat, 8'hA5);

        // Contention: both held and re-presented after each ack
        for (int i = 0; i < 3; i++) begin
            push_go({15'(15'h0100 + i), 2'b00}, 8'(8'hA0 + i), 1'b1);
            push_go(17'(17'h0_8000 + i), 8'(8'hB0 + i), 1'b1);
            push_exp(1'b0, 1'b0, 32'h0, -1);
            push_exp(1'b1, 1'b0, 32'h0, -1);
        end
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    a_req = 1'b1; a_we = 1'b1; a_sel = 4'b0001;
                    a_adr = 15'(15'h0100 + i); a_wdat = {24'h0, 8'(8'hA0 + i)};
                    wait_ack_a();
                end
                a_req = 1'b0;
            end
            begin
                @(negedge clk);
                for (int j = 0; j < 3; j++) begin
                    b_req = 1'b1; b_we = 1'b1;
                    b_adr = 17'(17'h0_8000 + j); b_wdat = 8'(8'hB0 + j);
                    wait_ack_b();
                end
                b_req = 1'b0;
            end
        join

        // Reset during lane 2 of an A word write: no ack, next grant waits on busy
        repeat (2) @(negedge clk);
        push_go(17'h0_0080, 8'hEF, 1'b1);
        push_go(17'h0_0081, 8'hBE, 1'b1);
        push_go(17'h0_0082, 8'hAD, 1'b1);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_adr = 15'h0020; a_sel = 4'hF; a_wdat = 32'hDEAD_BEEF;
        n_go = 0;
        for (int i = 0; i < 100 && n_go < 3; i++) begin
            @(negedge clk);
            if (m_go) n_go++;
        end
        if (n_go < 3) flag($sformatf("reset_setup: got %0d go pulses, required 3", n_go));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_go(17'h1_0005, 8'h00, 1'b0);
        b_req = 1'b1; b_we = 1'b0; b_adr = 17'h1_0005; b_wdat = 8'h00;
        push_exp(1'b1, 1'b1, 32'h0000_00A5, cyc + 1 + 12);
        wait_ack_b();
        b_req = 1'b0;

        repeat (20) @(negedge clk);
        chk("exp_a_drained", exp_a.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);
        chk("go_q_drained", go_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arb.md
# sram_arb

Two-port arbiter and sequencer in front of the 8-bit async SRAM controller (`sram`). It shares that single byte-wide resource between a 32-bit CPU port (word access with byte selects) and an 8-bit DMA port. Each granted request is split into byte cycles on the controller's `go`/`busy` handshake, and one `ack` pulse is returned when the whole access is done. Sits between the CPU/DMA bus fabric and `sram`.

## Interface
Parameters: none.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1 — system clock, 50 MHz, same clock as `sram`.
- `rst` input 1 — asynchronous, active-high reset.
- `a_req` input 1 — CPU request, level; held until `a_ack`.
- `a_we` input 1 — 1 = write, 0 = read.
- `a_adr` input 15 — word address; byte address = {`a_adr`, lane[1:0]}.
- `a_sel` input 4 — byte-lane selects; lane n = bits [8n+7:8n].
- `a_wdat` input 32 — write data.
- `a_rdat` output 32 — read data, registered.
- `a_ack` output 1 — one-cycle completion pulse.
- `b_req` input 1 — DMA request, level; held until `b_ack`.
- `b_we` input 1 — 1 = write, 0 = read.
- `b_adr` input 17 — byte address.
- `b_wdat` input 8 — write data.
- `b_rdat` output 8 — read data, registered.
- `b_ack` output 1 — one-cycle completion pulse.
- `m_go` output 1 — to `sram.go`; one-cycle pulse.
- `m_wr` output 1 — to `sram.wr`.
- `m_adr` output 17 — to `sram.adr`.
- `m_dat` output 8 — to `sram.dat`.
- `m_busy` input 1 — from `sram.busy`.
- `m_rdt` input 8 — from `sram.rdt`.

## Operation
- **Reset values:** all outputs 0; state IDLE; round-robin pointer `last` = B, so A wins the first tie.
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - Grant only when `m_busy`==0 and at least one request is present.
  - One requester present: grant it.
  - Both present: grant the port other than `last`, then set `last` to the granted port.
  - On grant, latch the port's we, address, write data and selects. A B grant is treated as 1 lane, lane 0, byte address `b_adr`.
  - Selected lanes ≠ 0: go to ISSUE. Selected lanes = 0 (A only): go directly to ACK with no SRAM cycle.
- **ISSUE**
  - `m_go`=1 for exactly one cycle.
  - `m_wr` = latched we.
  - `m_adr` = {adr, lane} for A, `b_adr` for B.
  - `m_dat` = latched byte of the current lane.
  - Next state: WAIT.
- **WAIT**
  - Hold `m_wr`, `m_adr` and `m_dat` stable.
  - On the first cycle with `m_busy`==0: for a read, capture `m_rdt` into the current lane of the granted port's read register.
  - Then advance to the next selected lane in ascending order (0→3); unselected lanes are skipped.
  - If a selected lane remains, go to ISSUE; otherwise go to ACK.
- **ACK:** assert the granted port's ack for one cycle, then go to IDLE.
- **Read data lanes**
  - On a read, unselected lanes of `a_rdat` are written 8'h00.
  - `a_rdat` and `b_rdat` hold their value until that port's next read completes.
  - Writes leave the read registers unchanged.
- **Request protocol**
  - A requester drops `req`, or presents a new request, in the cycle after its ack.
  - IDLE samples `req` again only after ACK, so a `req` still held is treated as a new transaction.
- **Request changes mid-transaction:** changes to the non-granted port's inputs are ignored until the next IDLE.
- **Reset mid-operation**
  - The arbiter returns to IDLE immediately and no ack is issued.
  - `sram` has no reset and finishes its cycle; IDLE blocks on `m_busy` until it does.

## Timing
- Cycle 0 = the cycle after the edge at which IDLE accepts the grant; `m_go` is high in cycle 0.
- `sram` reports busy for 6 cycles (cycles 1–6). WAIT sees `m_busy`==0 in cycle 7; read data is captured at the end of cycle 7.
- Each byte costs 8 cycles. For N selected lanes, ack is high in cycle 8N−1+1 = cycle 8N (N≥1). N=0 gives ack in cycle 0.
- Worst case: B single byte acks in cycle 8; A full word acks in cycle 32.
- Throughput: at most one new grant every 8N+2 cycles (IDLE and ACK overhead included).
- `m_go` is never high while `m_busy` is high, nor in two consecutive cycles.

## Test plan
- **B write then read:** `b_adr`=17'h1_0005, `b_wdat`=8'hA5, write → `b_ack` in cycle 8 and one `m_go` with `m_adr`=17'h1_0005, `m_dat`=8'hA5. Reading it back → `b_rdat`=8'hA5.
- **A word write/read:** `a_adr`=15'h0010, `a_sel`=4'hF, `a_wdat`=32'h1234_5678. Required: 4 byte cycles at addresses 0x40..0x43 carrying 78, 56, 34, 12; `a_ack` in cycle 32. Read back → `a_rdat`=32'h1234_5678.
- **Sparse selects:** `a_sel`=4'b1010 read → exactly 2 `m_go` pulses at lanes 1 and 3, `a_ack` in cycle 16, lanes 0 and 2 of `a_rdat` = 8'h00. `a_sel`=0 → `a_ack` in cycle 0 with no `m_go`.
- **Contention:** `a_req` and `b_req` asserted together and held, reasserted after each ack → grants alternate A, B, A, B. No `m_go` overlaps `m_busy`; acks never coincide.
- **Reset mid-word:** assert `rst` during lane 2 of an A write → no `a_ack`. After release, the next request's `m_go` waits until `m_busy` falls.
- **Protocol checks (bench model of `sram`):** `m_go` is always a single-cycle pulse; address and data are stable from ISSUE through WAIT.
